// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } key_event_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous key-event FIFO with registered head/valid; push and pop may coincide even when full.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  key_event_t push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output key_event_t head_o,
    output logic       overflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    key_event_t        mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;
    key_event_t        head_q, head_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              pop_eff;
    logic              wr_en;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop_eff    = pop_i & valid_q;
        wr_en      = push_i & (~full | pop_eff);
        rd_ptr_d   = pop_eff ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop_eff) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop_eff) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q | (push_i & full & ~pop_eff);
        valid_d    = (count_d != '0);
        // The next head slot may be the one being written this very cycle.
        if (!valid_d) begin
            head_d = '0;
        end else if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_o    = valid_q;
    assign head_o     = head_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: frame FSM, E0/F0 prefix folding, key-event FIFO, flap key level.
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter logic [7:0]  FLAP_CODE      = 8'h29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rd_en,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       flap_held,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic       ps2_dat_meta_q, ps2_dat_sync_q;
    logic       fall;
    logic       din;

    ps2_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
`ifdef PS2_PARITY_CHECK_EN
    logic       parity_q, parity_d;
`endif
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic       timeout;
    logic       stop_ok;

    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       flap_q, flap_d;
    logic       frame_err_q, frame_err_d;
    logic       push;
    key_event_t push_data;
    key_event_t head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_meta_q <= 1'b1;
            ps2_clk_sync_q <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_dat_meta_q <= 1'b1;
            ps2_dat_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q <= PS2_CLK;
            ps2_clk_sync_q <= ps2_clk_meta_q;
            ps2_clk_prev_q <= ps2_clk_sync_q;
            ps2_dat_meta_q <= PS2_DAT;
            ps2_dat_sync_q <= ps2_dat_meta_q;
        end
    end

    assign fall    = ps2_clk_prev_q & ~ps2_clk_sync_q;
    assign din     = ps2_dat_sync_q;
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif
        to_cnt_d    = (fall || state_q == IDLE) ? '0 : to_cnt_q + TW'(1);
        stop_ok     = 1'b0;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        flap_d      = flap_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        push_data   = '{code: shift_q, brk: brk_pend_q, ext: ext_pend_q};

        if (timeout) begin
            // A stalled partial frame is dropped silently.
            state_d    = IDLE;
            to_cnt_d   = '0;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = din;
`endif
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    stop_ok = din & (^{shift_q, parity_q});
`else
                    stop_ok = din;
`endif
                    if (!stop_ok) begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == PS2_PREFIX_BRK) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        push       = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                        if (!ext_pend_q && shift_q == FLAP_CODE) begin
                            flap_d = ~brk_pend_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
            to_cnt_q    <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            flap_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
            to_cnt_q    <= to_cnt_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            flap_q      <= flap_d;
            frame_err_q <= frame_err_d;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (rd_en),
        .valid_o     (key_valid),
        .head_o      (head),
        .overflow_o  (overflow)
    );

    assign key_code  = head.code;
    assign key_break = head.brk;
    assign key_ext   = head.ext;
    assign flap_held = flap_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver directly upstream of the ARMv4 core; consumes the raw PS2_CLK/PS2_DAT pins at the top level.
- Deserialises 11-bit frames, folds E0/F0 prefixes into key events, buffers events in a small FIFO, and exposes a pop handshake for the processor's memory-mapped input read.
- Also drives a level `flap_held` for the game's flap key.

Parameters:
- FIFO_DEPTH, 4, key-event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 2000, clk cycles without a falling PS2_CLK edge before a partial frame is discarded.
- FLAP_CODE, 8'h29, make/break code tracked by `flap_held` (space bar).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset; the block is in reset while reset=0
- PS2_CLK  in  1  raw PS/2 clock, asynchronous to clk
- PS2_DAT  in  1  raw PS/2 data, asynchronous to clk
- rd_en  in  1  pop the FIFO head; ignored when key_valid=0
- key_valid  out  1  FIFO not empty
- key_code  out  8  scan code at the FIFO head
- key_break  out  1  head event is a release (F0 prefix seen)
- key_ext  out  1  head event is extended (E0 prefix seen)
- flap_held  out  1  FLAP_CODE is currently pressed (non-extended)
- frame_err  out  1  one-cycle pulse when a frame is dropped
- overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; FSM in IDLE.
  - FIFO empty; prefix flags cleared.
  - Synchronisers preset to 1.
- Input capture:
  - PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser.
  - A falling edge is detected when the previous synced clock is 1 and the current synced clock is 0.
  - Data is sampled from the synced PS2_DAT on that cycle.
- Frame FSM, advancing only on a falling edge:
  - IDLE: if data=0 (start bit), go to DATA and clear bit_cnt; if data=1, stay in IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: if data=1 and parity is OK, the frame is good; otherwise pulse frame_err. Return to IDLE either way.
- Timeout:
  - The counter resets on every falling edge and counts while the FSM is not in IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE with no frame_err.
- Decoder, run on each good frame:
  - E0: set ext_pending; nothing is pushed.
  - F0: set brk_pending; nothing is pushed.
  - Any other code: push {code, brk_pending, ext_pending}, then clear both pending flags.
  - A dropped frame also clears both flags.
- flap_held:
  - Updated on every non-extended event with code == FLAP_CODE.
  - Set to 1 on make, 0 on break.
  - Updated even if the push is dropped on overflow.
- FIFO:
  - The push takes effect on the cycle after the STOP edge. key_valid and the head fields are registered, so the event is visible 1 cycle after the push.
  - The head fields are stable while key_valid=1 and there is no pop.
  - Pop: rd_en=1 with key_valid=1 advances the head on the next edge.
  - Simultaneous push and pop: both take effect and the count is unchanged, including when full.
  - Push when full without a pop: the event is dropped and overflow is set.
  - overflow clears only on reset.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs are glitch-free registered values.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the frame is good only if the stop bit is 1 and odd parity over data+parity holds. A bad frame pulses frame_err and is not decoded.
- Undefined: the parity bit is captured but ignored, and only the stop bit is checked. Parity-related logic is removed.

Decomposition:
- Package ps2_pkg:
  - typedef `ps2_state_t` {IDLE, DATA, PARITY, STOP}.
  - typedef packed struct `key_event_t` {code[7:0], brk, ext}.
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
- One sub-module, ps2_event_fifo: a parameterised synchronous FIFO of key_event_t with simultaneous push/pop semantics. The frame FSM and decoder stay in the parent.

Test Plan (PS/2 half-period 20 clk, TIMEOUT_CYCLES=2000, FIFO_DEPTH=4):
- Send frame 0x1C (parity 0, stop 1) -> key_valid=1 with key_code=8'h1C, key_break=0, key_ext=0 within 4 clk of the stop falling edge. rd_en for 1 cycle -> key_valid=0.
- Send F0 then 29 -> one event {29, brk=1, ext=0}. Preceding 29 make -> flap_held goes 1, then returns to 0 after the F0 29.
- Send E0 F0 75 -> a single event {75, brk=1, ext=1}; no event is pushed for the prefixes.
- Send 5 make codes 0x15,0x16,0x1D,0x1E,0x24 without reading -> overflow=1. Pops return 15,16,1D,1E, then key_valid=0. Assert rd_en on the cycle the 5th push lands -> no overflow, and the last entry is 24.
- Stop PS2_CLK after 4 data bits for 2500 clk, then send 0x1C -> no frame_err; exactly one event 0x1C.
- With PS2_PARITY_CHECK_EN, send 0x1C with parity=1 -> frame_err pulses 1 cycle and no event. Without the macro -> event 0x1C is delivered. Pull reset low mid-frame -> all outputs 0 immediately; the next full frame decodes correctly.
